// File: rtl/competition_sequencer.sv
// Competition-mode turn and timing controller: steps every player through every
// question with a preview countdown, an answer countdown, a verdict wait and a
// single score-update strobe per question.
module competition_sequencer #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int PREVIEW_S = 4,
  parameter int ANSWER_S  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] total,
  input  logic [2:0] players,
  input  logic       start,
  input  logic       confirm,
  input  logic       submit,
  input  logic       abort,
  input  logic       chk_valid,
  input  logic       chk_ok,
  output logic [5:0] q_idx,
  output logic [1:0] player,
  output logic [4:0] time_left,
  output logic [2:0] phase,
  output logic       answer_en,
  output logic       blink,
  output logic       score_we,
  output logic [4:0] score_time,
  output logic       score_ok,
  output logic       done
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(TICK_DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREVIEW = 3'd1,
    S_ANSWER  = 3'd2,
    S_JUDGE   = 3'd3,
    S_RESULT  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div, div_n;
  logic [5:0]    total_r, total_n;
  logic [2:0]    players_r, players_n;
  logic [5:0]    q_n;
  logic [1:0]    player_n;
  logic [4:0]    time_n;
  logic          blink_r, blink_n;
  logic          score_we_n;
  logic [4:0]    score_time_n;
  logic          score_ok_n;
  logic          tick;
  logic          start_ok;
  logic          counting;

  assign tick     = (div == DIV_LAST);
  assign counting = (state == S_PREVIEW) || (state == S_ANSWER);
  assign start_ok = start && (total >= 6'd1) && (total <= 6'd50) &&
                    (players >= 3'd1) && (players <= 3'd4);

  assign phase     = state;
  assign answer_en = (state == S_ANSWER);
  assign done      = (state == S_DONE);
  assign blink     = (state == S_PREVIEW) ? blink_r : (state != S_IDLE);

  // Registered state, counters and latched score values
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      div        <= '0;
      total_r    <= '0;
      players_r  <= '0;
      q_idx      <= '0;
      player     <= '0;
      time_left  <= '0;
      blink_r    <= 1'b0;
      score_we   <= 1'b0;
      score_time <= '0;
      score_ok   <= 1'b0;
    end else begin
      state      <= state_n;
      div        <= div_n;
      total_r    <= total_n;
      players_r  <= players_n;
      q_idx      <= q_n;
      player     <= player_n;
      time_left  <= time_n;
      blink_r    <= blink_n;
      score_we   <= score_we_n;
      score_time <= score_time_n;
      score_ok   <= score_ok_n;
    end
  end

  // Next-state and next-value logic; abort overrides everything at the end
  always_comb begin
    state_n      = state;
    total_n      = total_r;
    players_n    = players_r;
    q_n          = q_idx;
    player_n     = player;
    time_n       = time_left;
    blink_n      = blink_r;
    score_we_n   = 1'b0;
    score_time_n = score_time;
    score_ok_n   = score_ok;

    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_n   = S_PREVIEW;
          total_n   = total;
          players_n = players;
          q_n       = '0;
          player_n  = '0;
          time_n    = 5'(PREVIEW_S);
          blink_n   = 1'b1;
        end
      end
      S_PREVIEW: begin
        if (tick) begin
          if (time_left == 5'd1) begin
            state_n = S_ANSWER;
            time_n  = 5'(ANSWER_S);
          end else begin
            time_n  = time_left - 5'd1;
          end
        end
        if (tick || (div == DIV_HALF)) begin
          blink_n = ~blink_r;
        end
      end
      S_ANSWER: begin
        if (confirm) begin
          state_n      = S_JUDGE;
          score_time_n = 5'(ANSWER_S) - time_left;
        end else if (tick) begin
          if (time_left == 5'd1) begin
            state_n      = S_RESULT;
            score_time_n = 5'(ANSWER_S);
            score_ok_n   = 1'b0;
            score_we_n   = 1'b1;
          end else begin
            time_n = time_left - 5'd1;
          end
        end
      end
      S_JUDGE: begin
        if (chk_valid) begin
          state_n    = S_RESULT;
          score_ok_n = chk_ok;
          score_we_n = 1'b1;
        end
      end
      S_RESULT: begin
        if (submit) begin
          if (({1'b0, q_idx} + 7'd1) < {1'b0, total_r}) begin
            state_n = S_PREVIEW;
            q_n     = q_idx + 6'd1;
            time_n  = 5'(PREVIEW_S);
            blink_n = 1'b1;
          end else if (({1'b0, player} + 3'd1) < players_r) begin
            state_n  = S_PREVIEW;
            player_n = player + 2'd1;
            q_n      = '0;
            time_n   = 5'(PREVIEW_S);
            blink_n  = 1'b1;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Divider runs only while staying in a countdown state; any entry restarts it at 0
    if (counting && (state_n == state)) begin
      div_n = tick ? '0 : div + 1'b1;
    end else begin
      div_n = '0;
    end

    if (abort) begin
      state_n      = S_IDLE;
      q_n          = '0;
      player_n     = '0;
      time_n       = '0;
      blink_n      = 1'b0;
      score_we_n   = 1'b0;
      score_time_n = '0;
      score_ok_n   = 1'b0;
      div_n        = '0;
    end
  end

endmodule

// File: tb/tb_competition_sequencer.sv
// Self-checking bench for competition_sequencer: question-level reference model
// derived from countdown arithmetic, randomized confirm timing and verdicts.
module tb_competition_sequencer;

  localparam int TD = 4;
  localparam int PV = 2;
  localparam int AN = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] total = '0;
  logic [2:0] players = '0;
  logic       start = 1'b0, confirm = 1'b0, submit = 1'b0, abort = 1'b0;
  logic       chk_valid = 1'b0, chk_ok = 1'b0;
  logic [5:0] q_idx;
  logic [1:0] player;
  logic [4:0] time_left;
  logic [2:0] phase;
  logic       answer_en, blink, score_we, score_ok, done;
  logic [4:0] score_time;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int exp_we = 0;

  logic [25:0] outs;
  assign outs = {q_idx, player, time_left, phase, answer_en, blink,
                 score_we, score_time, score_ok, done};

  competition_sequencer #(.TICK_DIV(TD), .PREVIEW_S(PV), .ANSWER_S(AN)) dut (
    .clk(clk), .reset(reset), .total(total), .players(players),
    .start(start), .confirm(confirm), .submit(submit), .abort(abort),
    .chk_valid(chk_valid), .chk_ok(chk_ok),
    .q_idx(q_idx), .player(player), .time_left(time_left), .phase(phase),
    .answer_en(answer_en), .blink(blink), .score_we(score_we),
    .score_time(score_time), .score_ok(score_ok), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (score_we) we_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int t, input int p);
    total = 6'(t);
    players = 3'(p);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // One question from first PREVIEW cycle through submit. cc = answer cycle of
  // confirm (cc >= AN*TD means timeout).
  task automatic do_question(input int cc, input bit ok, input int q, input int p);
    int  st;
    bit  exp_ok;
    bit  confirmed;
    int  d;
    int  w;
    confirmed = 1'b0;
    check("pv_phase", phase, 1);
    check("pv_q", q_idx, q);
    check("pv_player", player, p);
    for (int k = 0; k < PV*TD; k++) begin
      check("pv_time", time_left, PV - k/TD);
      check("pv_blink", blink, ((k/(TD/2)) % 2 == 0) ? 1 : 0);
      check("pv_ans_en", answer_en, 0);
      confirm   = 1'($urandom_range(0, 1));
      submit    = 1'($urandom_range(0, 1));
      chk_valid = 1'($urandom_range(0, 1));
      chk_ok    = 1'b1;
      step();
    end
    confirm = 1'b0; submit = 1'b0; chk_valid = 1'b0;
    for (int k = 0; k < AN*TD; k++) begin
      if (!confirmed) begin
        check("an_phase", phase, 2);
        check("an_en", answer_en, 1);
        check("an_time", time_left, AN - k/TD);
        if (k == cc) begin
          confirm = 1'b1; submit = 1'b0; chk_valid = 1'b0;
          confirmed = 1'b1;
        end else begin
          submit    = 1'($urandom_range(0, 1));
          chk_valid = 1'($urandom_range(0, 1));
        end
        step();
        confirm = 1'b0;
      end
    end
    submit = 1'b0; chk_valid = 1'b0;
    if (confirmed) begin
      st = cc / TD;
      exp_ok = ok;
      check("jd_phase", phase, 3);
      check("jd_en", answer_en, 0);
      check("jd_time", score_time, st);
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        submit = 1'($urandom_range(0, 1));
        step();
        check("jd_wait", phase, 3);
      end
      submit = 1'b0;
      chk_valid = 1'b1; chk_ok = ok;
      step();
      chk_valid = 1'b0; chk_ok = 1'b0;
    end else begin
      st = AN;
      exp_ok = 1'b0;
    end
    check("rs_phase", phase, 4);
    check("rs_we", score_we, 1);
    check("rs_time", score_time, st);
    check("rs_ok", score_ok, exp_ok);
    check("rs_player", player, p);
    check("rs_q", q_idx, q);
    exp_we++;
    w = $urandom_range(0, 2);
    for (int i = 0; i < w; i++) begin
      step();
      check("rs_we_low", score_we, 0);
      check("rs_hold", phase, 4);
      check("rs_time_hold", score_time, st);
    end
    submit = 1'b1;
    step();
    submit = 1'b0;
  endtask

  // mode: 0 random, 1 confirm after one tick with ok, 2 timeout, 3 confirm on final tick
  task automatic run_round(input int t, input int pl, input int mode);
    int cc;
    bit ok;
    pulse_start(t, pl);
    for (int p = 0; p < pl; p++) begin
      for (int q = 0; q < t; q++) begin
        case (mode)
          1: begin cc = TD; ok = 1'b1; end
          2: begin cc = AN*TD; ok = 1'b1; end
          3: begin cc = AN*TD - 1; ok = 1'b1; end
          default: begin cc = $urandom_range(0, AN*TD); ok = 1'($urandom_range(0, 1)); end
        endcase
        do_question(cc, ok, q, p);
      end
    end
    check("dn_phase", phase, 5);
    check("dn_done", done, 1);
    check("dn_q", q_idx, t - 1);
    check("dn_player", player, pl - 1);
    check("dn_blink", blink, 1);
  endtask

  initial begin
    step();
    reset = 1'b0;
    check("reset_outs", int'(outs), 0);

    run_round(2, 1, 1);
    run_round(1, 1, 2);
    run_round(1, 3, 0);
    run_round(1, 1, 3);

    // abort during PREVIEW
    reset = 1'b1; step(); reset = 1'b0;
    pulse_start(2, 1);
    repeat (3) step();
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_pv_outs", int'(outs), 0);

    // abort during JUDGE
    pulse_start(2, 1);
    repeat (PV*TD + 1) step();
    check("pre_judge_phase", phase, 2);
    confirm = 1'b1; step(); confirm = 1'b0;
    check("judge_phase", phase, 3);
    abort = 1'b1; chk_valid = 1'b1; chk_ok = 1'b1;
    step();
    abort = 1'b0; chk_valid = 1'b0; chk_ok = 1'b0;
    check("abort_jd_outs", int'(outs), 0);
    step();
    check("abort_stays_idle", int'(outs), 0);
    check("we_after_abort", we_cnt, exp_we);

    run_round(2, 1, 0);
    reset = 1'b1; step(); reset = 1'b0;

    // invalid starts
    pulse_start(0, 1);  check("inv_total0", phase, 0);
    pulse_start(1, 5);  check("inv_players5", phase, 0);
    pulse_start(51, 1); check("inv_total51", phase, 0);
    pulse_start(1, 0);  check("inv_players0", phase, 0);

    // reset mid-ANSWER
    pulse_start(3, 2);
    repeat (PV*TD + 2) step();
    check("mid_answer", phase, 2);
    reset = 1'b1; step(); reset = 1'b0;
    check("reset_mid_outs", int'(outs), 0);

    for (int r = 0; r < 4; r++) begin
      run_round($urandom_range(1, 3), $urandom_range(1, 3), 0);
    end

    step();
    check("we_total", we_cnt, exp_we);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
